// File: rtl/spi_pkg.sv
// SPI slave shared types and defaults.
// Imported by the pin synchroniser and the slave core.
package spi_pkg;

  typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_e;

  localparam int SPI_SYNC_DEFAULT = 2;

endpackage

// File: rtl/spi_bus_if.sv
// SPI pin bundle between a master and a slave.
// The slave consumes cs_n/sck/mosi and drives miso.
interface spi_bus;

  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;

  modport master (
    output cs_n,
    output sck,
    output mosi,
    input  miso
  );

  modport slave (
    input  cs_n,
    input  sck,
    input  mosi,
    output miso
  );

endinterface

// File: rtl/spi_pin_sync.sv
// N-stage pin synchroniser plus a history flop.
// Gives the synced level and 1-cycle rise/fall strobes.
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // synchroniser chain then one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: oversampled pins, RX word pulse,
// TX holding register with valid/ready handshake.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int             DW          = 8,
  parameter bit             MSB_FIRST   = 1'b1,
  parameter int             SYNC_STAGES = SPI_SYNC_DEFAULT,
  parameter logic [DW-1:0]  IDLE_WORD   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_bus.slave         bus,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx_underrun,
  output logic          frame_abort,
  output logic          busy
);

  localparam int CW = $clog2(DW + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_pins;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .pin(bus.cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .pin(bus.sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .pin(bus.mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_pins = ^{cs_lvl, sck_lvl, mosi_rise, mosi_fall};

  spi_state_e    state_q, state_d;
  logic [CW-1:0] bit_cnt;
  logic          word_done;
  logic          rx_done;
  logic [DW-1:0] rx_shift;
  logic [DW-1:0] tx_shift;
  logic [DW-1:0] hold_q;
  logic          hold_full;

  logic active, do_rise, do_fall, last_bit;
  logic first_load, word_load, load, accept;

  // cs_rise wins over any sck strobe in the same cycle
  assign active     = (state_q == SPI_SHIFT) && !cs_rise;
  assign do_rise    = active && sck_rise;
  assign do_fall    = active && sck_fall;
  assign last_bit   = (bit_cnt == CW'(DW - 1));
  assign first_load = (state_q == SPI_IDLE) && cs_fall;
  assign word_load  = do_fall && word_done;
  assign load       = first_load || word_load;
  assign accept     = tx_valid && tx_ready;

  assign tx_ready = !hold_full;
  assign busy     = (state_q == SPI_SHIFT);
  assign bus.miso = (state_q == SPI_SHIFT) ?
                    (MSB_FIRST ? tx_shift[DW-1] : tx_shift[0]) :
                    1'b0;

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SPI_IDLE;
    else        state_q <= state_d;
  end

  // frame next-state: open on cs fall, close on cs rise
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SPI_IDLE:  if (cs_fall) state_d = SPI_SHIFT;
      SPI_SHIFT: if (cs_rise) state_d = SPI_IDLE;
      default:   state_d = SPI_IDLE;
    endcase
  end

  // bit counter, word-boundary flag and receive shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      word_done <= 1'b0;
      rx_done   <= 1'b0;
      rx_shift  <= '0;
    end else begin
      rx_done <= do_rise && last_bit;
      if (cs_rise) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (do_rise) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (last_bit) word_done <= 1'b1;
        if (MSB_FIRST) rx_shift <= {rx_shift[DW-2:0], mosi_s};
        else           rx_shift <= {mosi_s, rx_shift[DW-1:1]};
      end else if (word_load) begin
        word_done <= 1'b0;
      end
    end
  end

  // rx word register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= rx_done;
      tx_underrun <= word_load && !hold_full;
      frame_abort <= (state_q == SPI_SHIFT) && cs_rise &&
                     (bit_cnt != '0);
      if (rx_done) rx_data <= rx_shift;
    end
  end

  // tx holding register; a fresh word never joins the load under way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // tx shifter: load at word start, advance on non-boundary sck fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (load) begin
      tx_shift <= hold_full ? hold_q : IDLE_WORD;
    end else if (do_fall) begin
      if (MSB_FIRST) tx_shift <= {tx_shift[DW-2:0], 1'b0};
      else           tx_shift <= {1'b0, tx_shift[DW-1:1]};
    end
  end

endmodule
